phase_sample_capture: RTL

Downstream consumer of the interval timer's timeout. Each rising edge of the timer's interrupt output triggers one conversion on the external 8-channel parallel ADC (3 phase voltages, 3 phase currents, 2 spare). The block reads NUM_CH 16-bit results into a FIFO as one atomic frame. Nios II drains the FIFO through a 16-bit Avalon-MM slave and is interrupted at a programmable fill level.

---
 rtl/phase_capture_pkg.sv | 28 ++
 rtl/sample_fifo.sv | 61 ++++++
 rtl/phase_sample_capture.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/phase_capture_pkg.sv
// Shared constants for the phase sample capture block: register map,
// register bit positions and the conversion sequencer states.
package phase_capture_pkg;

  localparam logic [2:0] ADDR_STATUS  = 3'd0;
  localparam logic [2:0] ADDR_CONTROL = 3'd1;
  localparam logic [2:0] ADDR_DATA    = 3'd2;
  localparam logic [2:0] ADDR_LEVEL   = 3'd3;
  localparam logic [2:0] ADDR_THRESH  = 3'd4;

  localparam int ST_BUSY      = 0;
  localparam int ST_NONEMPTY  = 1;
  localparam int ST_OVERRUN   = 2;
  localparam int ST_TRIG_MISS = 3;
  localparam int ST_TIMEOUT   = 4;

  localparam int CTRL_ENABLE = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int CTRL_FLUSH  = 2;

  typedef enum logic [1:0] {
    IDLE,
    CONVST,
    WAIT,
    READ
  } state_t;

endpackage

// File: rtl/sample_fifo.sv
// Single-clock show-ahead FIFO for ADC sample words; level is 0..FIFO_DEPTH.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module sample_fifo #(
  parameter int WIDTH      = 16,
  parameter int FIFO_DEPTH = 64
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          push,
  input  logic                          pop,
  input  logic                          flush,
  input  logic [WIDTH-1:0]              wdata,
  output logic [WIDTH-1:0]              rdata,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          full,
  output logic                          empty
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic             do_push, do_pop;

  assign level   = wr_ptr_q - rd_ptr_q;
  assign full    = (level == LW'(FIFO_DEPTH));
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/phase_sample_capture.sv
// Timer-triggered capture of one NUM_CH-word frame from a parallel ADC into a
// FIFO drained by the CPU over a 16-bit register slave with a fill-level irq.
module phase_sample_capture
  import phase_capture_pkg::*;
#(
  parameter int NUM_CH        = 6,
  parameter int FIFO_DEPTH    = 64,
  parameter int CONVST_CYCLES = 4,
  parameter int RD_CYCLES     = 3,
  parameter int BUSY_TIMEOUT  = 1024
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        trig,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        read_n,
  input  logic        write_n,
  input  logic [15:0] writedata,
  output logic [15:0] readdata,
  output logic        irq,
  output logic        adc_convst,
  input  logic        adc_busy,
  output logic        adc_cs_n,
  output logic        adc_rd_n,
  input  logic [15:0] adc_data
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam int CW = $clog2(BUSY_TIMEOUT + CONVST_CYCLES + RD_CYCLES + 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    ch_q, ch_d;
  logic          trig_q, trig_d;
  logic          busy_meta_q, busy_meta_d;
  logic          busy_sync_q, busy_sync_d;
  logic          enable_q, enable_d;
  logic          irq_en_q, irq_en_d;
  logic          overrun_q, overrun_d;
  logic          trig_miss_q, trig_miss_d;
  logic          timeout_q, timeout_d;
  logic          discard_q, discard_d;
  logic [6:0]    thresh_q, thresh_d;
  logic [15:0]   readdata_q, readdata_d;
  logic          irq_q, irq_d;
  logic          adc_convst_q, adc_convst_d;
  logic          adc_cs_n_q, adc_cs_n_d;
  logic          adc_rd_n_q, adc_rd_n_d;

  logic          bus_rd, bus_wr, trig_edge, flush_now, push_slot, space_ok;
  logic [6:0]    thresh_eff;
  logic [15:0]   rd_val;
  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [15:0]   fifo_rdata;
  logic [LW-1:0] fifo_level;

  assign bus_rd     = chipselect && !read_n;
  assign bus_wr     = chipselect && !write_n;
  assign trig_edge  = trig && !trig_q;
  assign flush_now  = bus_wr && (address == ADDR_CONTROL) && writedata[CTRL_FLUSH];
  assign space_ok   = (fifo_level <= LW'(FIFO_DEPTH - NUM_CH));
  assign fifo_pop   = bus_rd && (address == ADDR_DATA) && !fifo_empty;
  assign fifo_push  = push_slot && !discard_q && !flush_now;
  assign thresh_eff = (thresh_q == 7'd0) ? 7'd1 : thresh_q;

  assign readdata   = readdata_q;
  assign irq        = irq_q;
  assign adc_convst = adc_convst_q;
  assign adc_cs_n   = adc_cs_n_q;
  assign adc_rd_n   = adc_rd_n_q;

  sample_fifo #(
    .WIDTH      (16),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .flush   (flush_now),
    .wdata   (adc_data),
    .rdata   (fifo_rdata),
    .level   (fifo_level),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ch_d        = ch_q;
    trig_d      = trig;
    busy_meta_d = adc_busy;
    busy_sync_d = busy_meta_q;
    enable_d    = enable_q;
    irq_en_d    = irq_en_q;
    overrun_d   = overrun_q;
    trig_miss_d = trig_miss_q;
    timeout_d   = timeout_q;
    discard_d   = discard_q;
    thresh_d    = thresh_q;
    readdata_d  = readdata_q;
    push_slot   = 1'b0;
    rd_val      = 16'd0;

    // Register writes first so a same-cycle hardware event wins over a clear.
    if (bus_wr) begin
      case (address)
        ADDR_STATUS: begin
          if (writedata[ST_OVERRUN])   overrun_d   = 1'b0;
          if (writedata[ST_TRIG_MISS]) trig_miss_d = 1'b0;
          if (writedata[ST_TIMEOUT])   timeout_d   = 1'b0;
        end
        ADDR_CONTROL: begin
          enable_d = writedata[CTRL_ENABLE];
          irq_en_d = writedata[CTRL_IRQ_EN];
        end
        ADDR_THRESH: thresh_d = writedata[6:0];
        default: ;
      endcase
    end

    case (state_q)
      IDLE: begin
        if (trig_edge && enable_q) begin
          if (space_ok) begin
            state_d   = CONVST;
            cnt_d     = '0;
            discard_d = 1'b0;
          end else begin
            overrun_d = 1'b1;
          end
        end
      end
      CONVST: begin
        if (cnt_q == CW'(CONVST_CYCLES - 1)) begin
          state_d = WAIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT: begin
        // The first two cycles cover the synchroniser delay on adc_busy.
        if ((cnt_q >= CW'(2)) && !busy_sync_q) begin
          state_d = READ;
          cnt_d   = '0;
          ch_d    = 3'd0;
        end else if (cnt_q == CW'(BUSY_TIMEOUT - 1)) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      READ: begin
        push_slot = (cnt_q == CW'(RD_CYCLES - 1));
        if (cnt_q == CW'(RD_CYCLES)) begin
          cnt_d = '0;
          if (ch_q == 3'(NUM_CH - 1)) state_d = IDLE;
          else                        ch_d    = ch_q + 3'd1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (trig_edge && (state_q != IDLE)) trig_miss_d = 1'b1;
    // A flush mid-frame drops the rest of that frame to keep the FIFO aligned.
    if (flush_now && (state_q != IDLE)) discard_d = 1'b1;

    case (address)
      ADDR_STATUS: begin
        rd_val[ST_BUSY]      = (state_q != IDLE);
        rd_val[ST_NONEMPTY]  = !fifo_empty;
        rd_val[ST_OVERRUN]   = overrun_q;
        rd_val[ST_TRIG_MISS] = trig_miss_q;
        rd_val[ST_TIMEOUT]   = timeout_q;
      end
      ADDR_CONTROL: begin
        rd_val[CTRL_ENABLE] = enable_q;
        rd_val[CTRL_IRQ_EN] = irq_en_q;
      end
      ADDR_DATA:   rd_val = fifo_empty ? 16'd0 : fifo_rdata;
      ADDR_LEVEL:  rd_val = 16'(fifo_level);
      ADDR_THRESH: rd_val = 16'(thresh_q);
      default:     rd_val = 16'd0;
    endcase
    if (bus_rd) readdata_d = rd_val;

    irq_d = irq_en_q && ((16'(fifo_level) >= 16'(thresh_eff)) || overrun_q || timeout_q);

    adc_convst_d = (state_d == CONVST);
    adc_cs_n_d   = (state_d != READ);
    adc_rd_n_d   = !((state_d == READ) && (cnt_d < CW'(RD_CYCLES)));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      ch_q         <= 3'd0;
      trig_q       <= 1'b0;
      busy_meta_q  <= 1'b0;
      busy_sync_q  <= 1'b0;
      enable_q     <= 1'b0;
      irq_en_q     <= 1'b0;
      overrun_q    <= 1'b0;
      trig_miss_q  <= 1'b0;
      timeout_q    <= 1'b0;
      discard_q    <= 1'b0;
      thresh_q     <= 7'(NUM_CH);
      readdata_q   <= 16'd0;
      irq_q        <= 1'b0;
      adc_convst_q <= 1'b0;
      adc_cs_n_q   <= 1'b1;
      adc_rd_n_q   <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ch_q         <= ch_d;
      trig_q       <= trig_d;
      busy_meta_q  <= busy_meta_d;
      busy_sync_q  <= busy_sync_d;
      enable_q     <= enable_d;
      irq_en_q     <= irq_en_d;
      overrun_q    <= overrun_d;
      trig_miss_q  <= trig_miss_d;
      timeout_q    <= timeout_d;
      discard_q    <= discard_d;
      thresh_q     <= thresh_d;
      readdata_q   <= readdata_d;
      irq_q        <= irq_d;
      adc_convst_q <= adc_convst_d;
      adc_cs_n_q   <= adc_cs_n_d;
      adc_rd_n_q   <= adc_rd_n_d;
    end
  end

endmodule
